// File: rtl/divn_cntr.sv
// Programmable modulo-N counter with terminal-count flag and glitch-free modulus reload at wrap/clr.
// Define DIVN_SQUARE_EN to build the registered divided square-wave output on sq_out.
module divn_cntr #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEF_MOD = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             mod_ld,
  input  logic [WIDTH-1:0] mod_in,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             mod_pend,
  output logic             sq_out
);

  localparam logic [WIDTH-1:0] DefMod = WIDTH'(DEF_MOD);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] cnt_r, mod_r, pend_mod;
  logic             pend_vld;

  logic [WIDTH-1:0] last;
  logic             at_last, wrap, apply, ld_ok;
  logic [WIDTH-1:0] nxt_cnt, nxt_mod, nxt_pend_mod;
  logic             nxt_pend_vld;

  // mod_r is never 0, so mod_r-1 cannot underflow.
  assign last    = mod_r - One;
  assign at_last = (cnt_r == last);
  assign wrap    = en & ~clr & at_last;
  assign apply   = clr | wrap;
  assign ld_ok   = mod_ld & (mod_in != '0);

  always_comb begin
    nxt_cnt      = cnt_r;
    nxt_mod      = mod_r;
    nxt_pend_mod = pend_mod;
    nxt_pend_vld = pend_vld;

    if (apply) begin
      nxt_cnt = '0;
    end else if (en) begin
      nxt_cnt = cnt_r + One;
    end

    // The modulus only changes when the count returns to 0, keeping cnt inside 0..mod_r-1.
    if (apply) begin
      if (ld_ok) begin
        nxt_mod = mod_in;
      end else if (pend_vld) begin
        nxt_mod = pend_mod;
      end
      nxt_pend_vld = 1'b0;
    end else if (ld_ok) begin
      nxt_pend_mod = mod_in;
      nxt_pend_vld = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      mod_r    <= DefMod;
      pend_mod <= '0;
      pend_vld <= 1'b0;
    end else begin
      cnt_r    <= nxt_cnt;
      mod_r    <= nxt_mod;
      pend_mod <= nxt_pend_mod;
      pend_vld <= nxt_pend_vld;
    end
  end

  assign cnt      = cnt_r;
  assign mod_pend = pend_vld;
  assign tc       = en & ~rst & ~clr & at_last;

`ifdef DIVN_SQUARE_EN
  logic [WIDTH:0] half;
  logic           sq_r;

  // High for ceil(M/2) counts of each period.
  assign half = ({1'b0, nxt_mod} + (WIDTH + 1)'(1)) >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_r <= 1'b1;
    end else begin
      sq_r <= ({1'b0, nxt_cnt} < half);
    end
  end

  assign sq_out = sq_r;
`else
  assign sq_out = 1'b0;
`endif

endmodule

// File: tb/tb_divn_cntr.sv
// Scoreboard bench for divn_cntr: an arithmetic model predicts each cycle's outputs into a queue,
// and a negedge monitor pops and compares against the DUT.
module tb_divn_cntr;
  localparam int W   = 4;
  localparam int DEF = 3;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         en     = 1'b0;
  logic         clr    = 1'b0;
  logic         mod_ld = 1'b0;
  logic [W-1:0] mod_in = '0;
  logic [W-1:0] cnt;
  logic         tc, mod_pend, sq_out;

  divn_cntr #(
    .WIDTH  (W),
    .DEF_MOD(DEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .mod_ld  (mod_ld),
    .mod_in  (mod_in),
    .cnt     (cnt),
    .tc      (tc),
    .mod_pend(mod_pend),
    .sq_out  (sq_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         tc;
    logic         pend;
    logic         sq;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model state: plain integers.
  int m_cnt  = 0;
  int m_mod  = DEF;
  int m_pmod = 0;
  bit m_pv   = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("cnt", int'(cnt), int'(e.cnt));
      chk("tc", int'(tc), int'(e.tc));
      chk("mod_pend", int'(mod_pend), int'(e.pend));
      chk("sq_out", int'(sq_out), int'(e.sq));
      cyc++;
    end
  end

  task automatic step(input bit r, input bit e, input bit c, input bit l, input int mi);
    exp_t x;
    bit   ldok, apply;
    @(posedge clk);
    #1;
    rst    = r;
    en     = e;
    clr    = c;
    mod_ld = l;
    mod_in = W'(mi);

    x.cnt  = W'(m_cnt);
    x.tc   = !r && !c && e && (m_cnt == m_mod - 1);
    x.pend = m_pv;
`ifdef DIVN_SQUARE_EN
    x.sq   = (m_cnt < (m_mod + 1) / 2);
`else
    x.sq   = 1'b0;
`endif
    sb.push_back(x);

    if (r) begin
      m_cnt  = 0;
      m_mod  = DEF;
      m_pmod = 0;
      m_pv   = 1'b0;
    end else begin
      apply = c || x.tc;
      ldok  = l && (mi != 0);
      if (c) m_cnt = 0;
      else if (e) m_cnt = (m_cnt + 1) % m_mod;
      if (apply) begin
        if (ldok) m_mod = mi;
        else if (m_pv) m_mod = m_pmod;
        m_pv = 1'b0;
      end else if (ldok) begin
        m_pmod = mi;
        m_pv   = 1'b1;
      end
    end
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 1'b0, 0);
  endtask

  // Advance until the count sits on its terminal value (stimulus steering only).
  task automatic to_last();
    for (int i = 0; i < 20 && m_cnt != m_mod - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    // Reset cycle with en and a load present: tc forced low, load ignored.
    step(1'b1, 1'b1, 1'b0, 1'b1, 6);
    run(7, 1'b1);                           // 0,1,2,0,1,2,0 at M=3
    step(1'b0, 1'b1, 1'b0, 1'b1, 5);        // load 5 while cnt=1
    run(8, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);        // zero modulus ignored
    run(1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1);        // pending M=1
    run(10, 1'b1);
    run(2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5);        // clr with load: M=5 directly
    run(3, 1'b1);
    run(4, 1'b0);                           // holds at 3
    step(1'b0, 1'b0, 1'b0, 1'b1, 7);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);        // clr applies pending 7
    run(10, 1'b1);
    to_last();
    step(1'b0, 1'b1, 1'b0, 1'b1, 9);        // load on the wrap cycle
    run(12, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 6);
    run(2, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);        // reset mid-count drops the pending value
    run(5, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4);
    run(8, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5);
    run(10, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 15);       // largest modulus
    run(18, 1'b1);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 15)));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
